// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg -- shared types and sizing helpers for the piso_tx transmitter.
//
// Contents:
//   state_e      : transmitter FSM states (IDLE, SHIFT, DONE)
//   PARITY_BITS  : 1 when PISO_TX_PARITY_EN is defined, otherwise 0
//   calc_nbits() : serial bits per frame for a given data width
//   cnt_width()  : width of a counter that must hold 0..n without wrapping
//
// Optional feature macro: PISO_TX_PARITY_EN (appends an even-parity bit).
package piso_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

`ifdef PISO_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 32'd1;
`else
    localparam int unsigned PARITY_BITS = 32'd0;
`endif

    // Frame length in serial bits: the data word plus the optional parity bit.
    function automatic int unsigned calc_nbits(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

    // ceil(log2(n+1)), floored at one bit so a counter always exists.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 32'd1);
        if (w < 32'd1) begin
            w = 32'd1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_tx_bit_tick_gen.sv
// bit_tick_gen -- DIV-cycle bit-period divider for piso_tx.
//
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   clr_i  : synchronous clear; holds the count at 0 while high
//   tick_o : high during the last (DIV-th) cycle of each bit period
module bit_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    // A one-bit counter is kept for DIV=1 so the compare below is always legal.
    localparam int unsigned CW = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on request, wrap after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// piso_tx -- parallel-in, serial-out transmitter, LSB first, one bit per DIV
// clocks, with a valid/ready input handshake.
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   valid_i : source offers data_i
//   data_i  : parallel word, sampled only on accept (valid_i && ready_o)
//   ready_o : high only in IDLE
//   q_o     : serial line, 0 outside a frame
//   frame_o : high while q_o carries a frame bit
//   done_o  : one-cycle pulse after the last frame bit
//
// Optional feature macro: PISO_TX_PARITY_EN appends an even-parity bit
// (XOR of the word) as the final serial bit.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             q_o,
    output logic             frame_o,
    output logic             done_o
);

    localparam int unsigned NBITS = calc_nbits(WIDTH);
    localparam int unsigned CNT_W = cnt_width(NBITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 32'd1);

    state_e             state_q;
    state_e             state_d;
    logic [NBITS-1:0]   shreg_q;
    logic [NBITS-1:0]   shreg_d;
    logic [CNT_W-1:0]   bitcnt_q;
    logic [CNT_W-1:0]   bitcnt_d;
    logic               tick_s;
    logic               accept_s;
    logic [NBITS-1:0]   load_word_s;

`ifdef PISO_TX_PARITY_EN
    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    assign load_word_s = {even_parity(data_i), data_i};
`else
    assign load_word_s = data_i;
`endif

    assign accept_s = valid_i && (state_q == ST_IDLE);

    // The divider only runs while a frame is on the line, so each frame's
    // first bit gets a full DIV cycles.
    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_q != ST_SHIFT),
        .tick_o (tick_s)
    );

    // Next-state logic for the FSM, shift register and bit counter.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shreg_d  = load_word_s;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (tick_s) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register and bit counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Outputs decode registered state only; nothing depends on valid_i.
    assign ready_o = (state_q == ST_IDLE);
    assign frame_o = (state_q == ST_SHIFT);
    assign done_o  = (state_q == ST_DONE);
    assign q_o     = (state_q == ST_SHIFT) && shreg_q[0];

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx -- scoreboard bench for piso_tx. Two instances: DIV=4 and DIV=1.
// A reference model pushes the expected per-cycle line state on each accept;
// a monitor pops one entry per cycle at the falling edge and compares.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk;
    logic       rst_i;
    logic       vld     [2];
    logic [3:0] dat     [2];
    logic       q_w     [2];
    logic       frame_w [2];
    logic       done_w  [2];
    logic       ready_w [2];

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] frame_word(input logic [3:0] d);
        logic [NB-1:0] w;
`ifdef PISO_TX_PARITY_EN
        w = {^d, d};
`else
        w = d;
`endif
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIVG = (g == 0) ? 4 : 1;

        logic [1:0] exp_q[$];   // {is_done, bit}
        int         busy = 0;
        int         acc_cnt = 0;
        logic [3:0] last_word = 4'd0;

        piso_tx #(.WIDTH(4), .DIV(DIVG)) u_dut (
            .clk_i   (clk),
            .rst_i   (rst_i),
            .valid_i (vld[g]),
            .data_i  (dat[g]),
            .ready_o (ready_w[g]),
            .q_o     (q_w[g]),
            .frame_o (frame_w[g]),
            .done_o  (done_w[g])
        );

        // Reference model: decides accepts independently and queues the frame.
        always @(posedge clk) begin
            logic [NB-1:0] w;
            if (!rst_i) begin
                exp_q.delete();
                busy = 0;
            end else if (busy != 0) begin
                busy--;
            end else if (vld[g]) begin
                w = frame_word(dat[g]);
                for (int i = 0; i < NB; i++) begin
                    for (int j = 0; j < DIVG; j++) exp_q.push_back({1'b0, w[i]});
                end
                exp_q.push_back(2'b10);
                busy = NB * DIVG + 1;
                acc_cnt++;
                last_word = dat[g];
            end
        end

        // Monitor: {ready, frame, done, q} compared every cycle.
        always @(negedge clk) begin
            logic [1:0] e;
            logic [3:0] exp_v;
            if (!rst_i) begin
                exp_q.delete();
                exp_v = 4'b1000;
            end else if (exp_q.size() == 0) begin
                exp_v = 4'b1000;
            end else begin
                e = exp_q.pop_front();
                exp_v = e[1] ? 4'b0010 : {3'b010, e[0]};
            end
            check((g == 0) ? "outs_div4" : "outs_div1",
                  {ready_w[g], frame_w[g], done_w[g], q_w[g]}, exp_v);
        end
    end

    function automatic int get_acc(input int g);
        if (g == 0) return g_dut[0].acc_cnt;
        else return g_dut[1].acc_cnt;
    endfunction

    // Waits (bounded) for the model to record an accept beyond start.
    task automatic wait_acc(input int g, input int start);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (get_acc(g) != start) return;
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=none expected=accept on dut %0d", g);
    endtask

    task automatic send(input int g, input logic [3:0] w);
        int s;
        @(posedge clk);
        #2;
        vld[g] = 1'b1;
        dat[g] = w;
        s = get_acc(g);
        wait_acc(g, s);
        vld[g] = 1'b0;
    endtask

    initial begin
        int s;
        bit got;
        checks   = 0;
        failures = 0;
        rst_i    = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0;
        dat[0] = 4'd0; dat[1] = 4'd0;
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b1;

        // Idle for 20 cycles: monitor expects ready=1 and a quiet line.
        repeat (20) @(posedge clk);

        // Single frame 1011.
        send(0, 4'b1011);
        repeat (NB * 4 + 4) @(posedge clk);

        // Valid held high, data changing every cycle during a 0110 frame.
        @(posedge clk);
        #2;
        vld[0] = 1'b1;
        dat[0] = 4'b0110;
        s = get_acc(0);
        wait_acc(0, s);
        #1 dat[0] = 4'd1;
        got = 1'b0;
        for (int j = 2; j < 60; j++) begin
            @(posedge clk);
            #1;
            if (get_acc(0) != s + 1) begin
                got = 1'b1;
                break;
            end
            #1 dat[0] = j[3:0];
        end
        vld[0] = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL busy_second_accept actual=none expected=accept");
        end
`ifdef PISO_TX_PARITY_EN
        check("busy_next_word", g_dut[0].last_word, 4'h6);
`else
        check("busy_next_word", g_dut[0].last_word, 4'h2);
`endif
        repeat (NB * 4 + 4) @(posedge clk);

        // Reset in cycle 7 of a 1111 frame, then a clean 0001 frame.
        send(0, 4'b1111);
        repeat (6) @(posedge clk);
        #2 rst_i = 1'b0;
        #1;
        check("rst_async_q",     {3'b000, q_w[0]},     4'b0000);
        check("rst_async_frame", {3'b000, frame_w[0]}, 4'b0000);
        check("rst_async_done",  {3'b000, done_w[0]},  4'b0000);
        check("rst_async_ready", {3'b000, ready_w[0]}, 4'b0001);
        @(posedge clk);
        #2 rst_i = 1'b1;
        repeat (3) @(posedge clk);
        send(0, 4'b0001);
        repeat (NB * 4 + 4) @(posedge clk);

        // 0111: with parity the fifth bit is 1.
        send(0, 4'b0111);
        repeat (NB * 4 + 4) @(posedge clk);

        // DIV=1 back-to-back A then 5, valid held continuously.
        @(posedge clk);
        #2;
        vld[1] = 1'b1;
        dat[1] = 4'hA;
        s = get_acc(1);
        wait_acc(1, s);
        dat[1] = 4'h5;
        wait_acc(1, s + 1);
        vld[1] = 1'b0;
        repeat (NB + 6) @(posedge clk);
        check("div1_accepts", 4'(get_acc(1) - s), 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
